// File: rtl/scan_cfg_pkg.sv
// scan_cfg_pkg: state encoding and default word width shared by the scan
// configuration controller and its serializer.
// Optional feature macro: SCAN_CFG_READBACK_EN (adds the RB_WAIT state).
package scan_cfg_pkg;

   localparam int WORD_W_DEFAULT = 32;

`ifdef SCAN_CFG_READBACK_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE,
      ST_RB_WAIT
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } state_e;
`endif

endpackage

// File: rtl/scan_cfg_ser.sv
// scan_cfg_ser: per-word serializer. Holds the configuration word being shifted
// onto the chain, its bit length, and how many of its bits have already gone out.
module scan_cfg_ser import scan_cfg_pkg::*; #(
   parameter int WORD_W = WORD_W_DEFAULT,
   parameter int BW     = $clog2(WORD_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] word,
   input  logic [BW-1:0]     word_bits,
   output logic              next_bit,
   output logic              last_bit,
   output logic [BW-1:0]     bit_idx
);

   logic [WORD_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     len_q, len_d;

   // Next word register and bit counter; a fresh load takes priority over shifting.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      if (clear) begin
         shift_d = '0;
         cnt_d   = '0;
         len_d   = '0;
      end else if (load) begin
         shift_d = word;
         cnt_d   = '0;
         len_d   = word_bits;
      end else if (shift) begin
         shift_d = shift_q >> 1;
         cnt_d   = last_bit ? '0 : cnt_q + BW'(1);
      end
   end

   // Word register, counter and length flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   // The bit the chain will see next cycle is whatever lands in position 0.
   assign next_bit = shift_d[0];
   assign last_bit = (cnt_q == len_q - BW'(1));
   assign bit_idx  = cnt_q;

endmodule

// File: rtl/scan_cfg_ctrl.sv
// scan_cfg_ctrl: loads CHAIN_LEN configuration bits into a scan chain, one
// WORD_W word at a time, LSB first, with a one-cycle LOAD bubble per word.
// Optional feature macro: SCAN_CFG_READBACK_EN captures the bits leaving the
// chain tail per word and holds the FSM in RB_WAIT until they are taken.
module scan_cfg_ctrl import scan_cfg_pkg::*; #(
   parameter int CHAIN_LEN = 1024,
   parameter int WORD_W    = WORD_W_DEFAULT
) (
   input  logic              scan_clk,
   input  logic              scan_rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              conn_scan_en,
   output logic              conn_scan_in,
   input  logic              conn_scan_out,
   output logic              busy,
   output logic              done
`ifdef SCAN_CFG_READBACK_EN
   ,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   input  logic              rb_ready
`endif
);

   localparam int TOT_W = $clog2(CHAIN_LEN + 1);
   localparam int BW    = $clog2(WORD_W + 1);

   state_e           state_q, state_d;
   logic [TOT_W-1:0] total_q, total_d, total_inc, remaining;
   logic [BW-1:0]    word_bits;
   logic             cfg_ready_q, cfg_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             en_q, en_d;
   logic             in_q, in_d;
   logic             ser_load, ser_shift, ser_next_bit, ser_last_bit;
   logic [BW-1:0]    ser_bit_idx;
`ifdef SCAN_CFG_READBACK_EN
   logic [WORD_W-1:0] rb_q, rb_d;
   logic              rb_valid_q, rb_valid_d;
`else
   logic [BW:0]       unused_sigs;
   assign unused_sigs = {conn_scan_out, ser_bit_idx};
`endif

   assign total_inc = total_q + TOT_W'(1);
   assign remaining = TOT_W'(CHAIN_LEN) - total_q;
   // Only the final word can be short; it carries whatever the chain still needs.
   assign word_bits = ({{(32-TOT_W){1'b0}}, remaining} < 32'(WORD_W)) ? BW'(remaining) : BW'(WORD_W);

   scan_cfg_ser #(.WORD_W(WORD_W), .BW(BW)) u_ser (
      .clk       (scan_clk),
      .rst_n     (scan_rst_n),
      .clear     (abort),
      .load      (ser_load),
      .shift     (ser_shift),
      .word      (cfg_data),
      .word_bits (word_bits),
      .next_bit  (ser_next_bit),
      .last_bit  (ser_last_bit),
      .bit_idx   (ser_bit_idx)
   );

   // Next-state and next-output decode; abort overrides everything else.
   always_comb begin
      state_d   = state_q;
      total_d   = total_q;
      ser_load  = 1'b0;
      ser_shift = 1'b0;
      en_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               total_d = '0;
            end
         end
         ST_LOAD: begin
            if (cfg_valid && cfg_ready_q) begin
               ser_load = 1'b1;
               state_d  = ST_SHIFT;
               en_d     = 1'b1;
            end
         end
         ST_SHIFT: begin
            ser_shift = 1'b1;
            total_d   = total_inc;
            if (ser_last_bit) begin
`ifdef SCAN_CFG_READBACK_EN
               state_d = ST_RB_WAIT;
`else
               state_d = (total_inc == TOT_W'(CHAIN_LEN)) ? ST_DONE : ST_LOAD;
`endif
            end else begin
               en_d = 1'b1;
            end
         end
`ifdef SCAN_CFG_READBACK_EN
         ST_RB_WAIT: begin
            if (rb_ready) begin
               state_d = (total_q == TOT_W'(CHAIN_LEN)) ? ST_DONE : ST_LOAD;
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (abort) begin
         state_d   = ST_IDLE;
         ser_load  = 1'b0;
         ser_shift = 1'b0;
         en_d      = 1'b0;
      end
      cfg_ready_d = (state_d == ST_LOAD);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
   end

   // The serial data flop only carries a bit while the enable flop is set.
   assign in_d = en_d & ser_next_bit;

`ifdef SCAN_CFG_READBACK_EN
   // Readback word: cleared per word, then one tail bit per shift cycle in arrival order.
   always_comb begin
      rb_d = rb_q;
      if (ser_load) begin
         rb_d = '0;
      end else if (ser_shift) begin
         rb_d = rb_q | (WORD_W'(conn_scan_out) << ser_bit_idx);
      end
      rb_valid_d = (state_d == ST_RB_WAIT);
   end
`endif

   // FSM state, bit total and all registered outputs.
   always_ff @(posedge scan_clk or negedge scan_rst_n) begin
      if (!scan_rst_n) begin
         state_q     <= ST_IDLE;
         total_q     <= '0;
         cfg_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         en_q        <= 1'b0;
         in_q        <= 1'b0;
`ifdef SCAN_CFG_READBACK_EN
         rb_q        <= '0;
         rb_valid_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         total_q     <= total_d;
         cfg_ready_q <= cfg_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         en_q        <= en_d;
         in_q        <= in_d;
`ifdef SCAN_CFG_READBACK_EN
         rb_q        <= rb_d;
         rb_valid_q  <= rb_valid_d;
`endif
      end
   end

   assign cfg_ready    = cfg_ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign conn_scan_en = en_q;
   assign conn_scan_in = in_q;
`ifdef SCAN_CFG_READBACK_EN
   assign rb_data      = rb_q;
   assign rb_valid     = rb_valid_q;
`endif

endmodule

// File: tb/tb_scan_cfg_ctrl.sv
// tb_scan_cfg_ctrl: randomized bench for scan_cfg_ctrl with a 40-bit chain and
// a loopback chain model. A transaction-level model predicts every output each cycle.
// Optional feature macro: SCAN_CFG_READBACK_EN (readback ports and checks).
module tb_scan_cfg_ctrl;

   localparam int CHAIN_LEN = 40;
   localparam int WORD_W    = 32;
`ifdef SCAN_CFG_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif
   localparam int PH_IDLE = 0, PH_WORD = 1, PH_SHIFT = 2, PH_RB = 3, PH_DONE = 4;

   logic scan_clk = 1'b0;
   logic scan_rst_n = 1'b0;
   logic start = 1'b0, abort = 1'b0, cfg_valid = 1'b0, rbReady = 1'b0;
   logic [WORD_W-1:0] cfg_data = '0;
   logic cfg_ready, conn_scan_en, conn_scan_in, conn_scan_out, busy, done;
`ifdef SCAN_CFG_READBACK_EN
   logic [WORD_W-1:0] rb_data;
   logic rb_valid;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Chain model: shifts toward the tail whenever the controller enables it.
   logic [CHAIN_LEN-1:0] chain = '0;
   logic [CHAIN_LEN-1:0] preloadVal = '0;
   logic preloadReq = 1'b0;

   // Monitor state for the current transaction.
   int runEn, runDone, runRises, cycle, lastEnCycle, doneGap;
   bit prevEn = 1'b0;
   bit runStream[$];
   logic [WORD_W-1:0] rbSeen[$];

   // Behavioural model state.
   int mPhase = PH_IDLE;
   int mShifted = 0;
   bit mQ[$];
   logic [WORD_W-1:0] mRb = '0;
   int mRbIdx = 0;

   always #5 scan_clk = ~scan_clk;

   scan_cfg_ctrl #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
      .scan_clk      (scan_clk),
      .scan_rst_n    (scan_rst_n),
      .start         (start),
      .abort         (abort),
      .cfg_data      (cfg_data),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .conn_scan_en  (conn_scan_en),
      .conn_scan_in  (conn_scan_in),
      .conn_scan_out (conn_scan_out),
      .busy          (busy),
      .done          (done)
`ifdef SCAN_CFG_READBACK_EN
      ,
      .rb_data       (rb_data),
      .rb_valid      (rb_valid),
      .rb_ready      (rbReady)
`endif
   );

   assign conn_scan_out = chain[0];

   // Loopback chain register with an optional preload while idle.
   always @(posedge scan_clk) begin
      if (preloadReq) chain <= preloadVal;
      else if (conn_scan_en) chain <= {conn_scan_in, chain[CHAIN_LEN-1:1]};
   end

   // Reference model: per word, queue the bits the chain must receive and track the total.
   always @(posedge scan_clk or negedge scan_rst_n) begin
      if (!scan_rst_n) begin
         mPhase = PH_IDLE;
         mShifted = 0;
         mQ.delete();
         mRb = '0;
         mRbIdx = 0;
      end else if (abort) begin
         mPhase = PH_IDLE;
         mQ.delete();
      end else begin
         case (mPhase)
            PH_IDLE: if (start) begin
               mPhase = PH_WORD;
               mShifted = 0;
            end
            PH_WORD: if (cfg_valid) begin
               int n;
               n = CHAIN_LEN - mShifted;
               if (n > WORD_W) n = WORD_W;
               for (int i = 0; i < n; i++) mQ.push_back(cfg_data[i]);
               mRb = '0;
               mRbIdx = 0;
               mPhase = PH_SHIFT;
            end
            PH_SHIFT: begin
               mRb[mRbIdx] = chain[0];
               mRbIdx++;
               void'(mQ.pop_front());
               mShifted++;
               if (mQ.size() == 0) begin
                  if (READBACK) mPhase = PH_RB;
                  else mPhase = (mShifted == CHAIN_LEN) ? PH_DONE : PH_WORD;
               end
            end
            PH_RB: if (rbReady) mPhase = (mShifted == CHAIN_LEN) ? PH_DONE : PH_WORD;
            default: mPhase = PH_IDLE;
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle: record the serial stream and compare all outputs with the model.
   always @(negedge scan_clk) begin
      logic expIn;
      cycle++;
      if (conn_scan_en) begin
         runEn++;
         runStream.push_back(conn_scan_in);
         lastEnCycle = cycle;
         if (!prevEn) runRises++;
      end
      if (done) begin
         runDone++;
         doneGap = cycle - lastEnCycle;
      end
      prevEn = conn_scan_en;
      expIn = (mPhase == PH_SHIFT && mQ.size() > 0) ? mQ[0] : 1'b0;
      checkOutput("busy", busy, mPhase != PH_IDLE);
      checkOutput("cfg_ready", cfg_ready, mPhase == PH_WORD);
      checkOutput("conn_scan_en", conn_scan_en, mPhase == PH_SHIFT);
      checkOutput("conn_scan_in", conn_scan_in, expIn);
      checkOutput("done", done, mPhase == PH_DONE);
`ifdef SCAN_CFG_READBACK_EN
      checkOutput("rb_valid", rb_valid, mPhase == PH_RB);
      if (mPhase == PH_RB) checkOutput("rb_data", rb_data, mRb);
`endif
   end

   task automatic applyStimulus(input logic s, input logic a, input logic v,
                                input logic [WORD_W-1:0] d, input logic rr);
      start = s;
      abort = a;
      cfg_valid = v;
      cfg_data = d;
      rbReady = rr;
      @(negedge scan_clk);
      #1;
   endtask

   task automatic clearRun();
      runEn = 0;
      runDone = 0;
      runRises = 0;
      doneGap = -1;
      runStream.delete();
      rbSeen.delete();
   endtask

   function automatic logic [39:0] streamBits();
      logic [39:0] r;
      r = '0;
      for (int i = 0; i < runStream.size() && i < 40; i++) r[i] = runStream[i];
      return r;
   endfunction

   // One start-to-done (or abort) transaction with configurable stalls and noise.
   task automatic runLoad(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                          input int validDelay, input int rbDelay, input int abortAt,
                          input bit noise);
      logic [WORD_W-1:0] w[2];
      int wi, vStall, rStall;
      bit fin;
      w[0] = w0;
      w[1] = w1;
      wi = 0;
      vStall = validDelay;
      rStall = rbDelay;
      fin = 1'b0;
      clearRun();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int c = 0; c < 400 && !fin; c++) begin
         logic s, a, v, rr;
         logic [WORD_W-1:0] d;
         s = noise && busy && ($urandom_range(0, 3) == 0);
         a = (abortAt >= 0) && (runEn == abortAt);
         v = 1'b0;
         d = $urandom;
         rr = 1'b0;
         if (cfg_ready && wi < 2) begin
            if (vStall == 0) begin
               v = 1'b1;
               d = w[wi];
               wi++;
               vStall = validDelay;
            end else begin
               vStall--;
            end
         end else if (noise) begin
            v = ($urandom_range(0, 1) == 1);
         end
`ifdef SCAN_CFG_READBACK_EN
         if (rb_valid) begin
            if (rStall == 0) begin
               rr = 1'b1;
               rStall = rbDelay;
               rbSeen.push_back(rb_data);
            end else begin
               rStall--;
            end
         end else if (noise) begin
            rr = ($urandom_range(0, 1) == 1);
         end
`endif
         applyStimulus(s, a, v, d, rr);
         if (a) begin
            fin = 1'b1;
            checkOutput("abort_busy", busy, 1'b0);
            checkOutput("abort_en", conn_scan_en, 1'b0);
         end else if (runDone > 0) begin
            fin = 1'b1;
         end
      end
      checkOutput("run_finished", fin, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [WORD_W-1:0] a0, a1;
      logic enBefore;
      $display("[TB] scan_cfg_ctrl bench, CHAIN_LEN=%0d WORD_W=%0d", CHAIN_LEN, WORD_W);
      repeat (3) @(negedge scan_clk);
      #1;
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_ready", cfg_ready, 1'b0);
      checkOutput("reset_en", conn_scan_en, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      scan_rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

      // Two-word load with a short final word: A5 pattern then eight ones.
      runLoad(32'hA5A5A5A5, 32'h000000FF, 0, 0, -1, 1'b0);
      checkOutput("a5_stream", streamBits(), 40'hFF_A5A5A5A5);
      checkOutput("a5_shifts", runEn, 40);
      checkOutput("a5_bursts", runRises, 2);
      checkOutput("a5_done_count", runDone, 1);
`ifndef SCAN_CFG_READBACK_EN
      checkOutput("a5_done_gap", doneGap, 1);
`endif

      // Producer stalls ten cycles per word while the controller waits in LOAD.
      a0 = $urandom;
      a1 = $urandom;
      runLoad(a0, a1, 10, 0, -1, 1'b0);
      checkOutput("stall_shifts", runEn, 40);
      checkOutput("stall_bursts", runRises, 2);
      checkOutput("stall_stream", streamBits(), {a1[7:0], a0});

      // Abort during the 17th shift, then a full reload.
      runLoad(a0, a1, 0, 0, 17, 1'b0);
      checkOutput("abort_shifts", runEn, 17);
      checkOutput("abort_done_count", runDone, 0);
      runLoad(a0, a1, 0, 0, -1, 1'b0);
      checkOutput("reload_shifts", runEn, 40);
      checkOutput("reload_stream", streamBits(), {a1[7:0], a0});

`ifdef SCAN_CFG_READBACK_EN
      // Loopback readback of a preloaded chain with a slow consumer.
      preloadVal = 40'h12_3456789A;
      preloadReq = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      preloadReq = 1'b0;
      runLoad(a0, a1, 0, 5, -1, 1'b0);
      checkOutput("rb_count", rbSeen.size(), 2);
      checkOutput("rb_word0", rbSeen[0], 32'h3456789A);
      checkOutput("rb_word1", rbSeen[1], 32'h00000012);
      checkOutput("rb_shifts", runEn, 40);
`endif

      // Asynchronous reset in the middle of shifting.
      clearRun();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int c = 0; c < 60 && runEn < 10; c++) applyStimulus(1'b0, 1'b0, cfg_ready, $urandom, 1'b0);
      @(posedge scan_clk);
      #2;
      enBefore = conn_scan_en;
      scan_rst_n = 1'b0;
      #1;
      checkOutput("pre_reset_en", enBefore, 1'b1);
      checkOutput("async_rst_en", conn_scan_en, 1'b0);
      checkOutput("async_rst_in", conn_scan_in, 1'b0);
      checkOutput("async_rst_busy", busy, 1'b0);
      checkOutput("async_rst_ready", cfg_ready, 1'b0);
      checkOutput("async_rst_done", done, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      scan_rst_n = 1'b1;
      clearRun();
      for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 1'b1, $urandom, 1'b1);
      checkOutput("no_start_busy", busy, 1'b0);
      checkOutput("no_start_shifts", runEn, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

      // Randomized transactions with start/valid noise, stalls and occasional aborts.
      for (int r = 0; r < 20; r++) begin
         int ab;
         a0 = $urandom;
         a1 = $urandom;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 39)) : -1;
         runLoad(a0, a1, $urandom_range(0, 3), $urandom_range(0, 3), ab, 1'b1);
         if (ab < 0) begin
            checkOutput("rand_done_count", runDone, 1);
            checkOutput("rand_stream", streamBits(), {a1[7:0], a0});
         end else begin
            checkOutput("rand_abort_done", runDone, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
